// File: rtl/thor2022_operand_fetch.sv
// Thor2022 operand fetch: register file, pending-write scoreboard,
// writeback bypass and valid/ready handshake towards execute.
module thor2022_operand_fetch #(
    parameter int WID   = 64,
    parameter int NREGS = 48
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           dv_i,
    output logic           dready_o,
    input  logic [5:0]     Ra_i,
    input  logic [5:0]     Rb_i,
    input  logic [5:0]     Rc_i,
    input  logic [5:0]     Rt_i,
    input  logic           wrt_i,
    output logic           ov_o,
    input  logic           ordy_i,
    output logic [WID-1:0] a_o,
    output logic [WID-1:0] b_o,
    output logic [WID-1:0] c_o,
    output logic [5:0]     Rt_o,
    output logic           wrt_o,
    input  logic           wb_v_i,
    input  logic [5:0]     wb_Rt_i,
    input  logic [WID-1:0] wb_res_i,
    input  logic           flush_i
);

    // Holes at 32-40 and 43 are not backed by storage.
    function automatic logic impl_f(input logic [5:0] r);
        impl_f = (int'(r) < NREGS) && !(r >= 6'd32 && r <= 6'd40)
                 && (r != 6'd43);
    endfunction

    // r0 is hardwired to zero, so it is never written nor pending.
    function automatic logic wr_ok_f(input logic [5:0] r);
        wr_ok_f = impl_f(r) && (r != 6'd0);
    endfunction

    logic [WID-1:0] rf_q [NREGS];
    logic [WID-1:0] rf_d [NREGS];
    logic [NREGS-1:0] pend_q, pend_d;
    logic           ov_q, ov_d;
    logic [WID-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [5:0]     rt_q, rt_d;
    logic           wrt_q, wrt_d;

    logic [5:0]     src [3];
    logic [WID-1:0] opnd [3];
    logic           hazard;
    logic           acc;

    // Source read with same-cycle writeback bypass and interlock check.
    always_comb begin
        src[0] = Ra_i;
        src[1] = Rb_i;
        src[2] = Rc_i;
        hazard = 1'b0;
        for (int k = 0; k < 3; k++) begin
            opnd[k] = '0;
            if (wb_v_i && wb_Rt_i == src[k] && wr_ok_f(src[k]))
                opnd[k] = wb_res_i;
            else if (wr_ok_f(src[k]))
                opnd[k] = rf_q[src[k]];
            if (wr_ok_f(src[k]) && pend_q[src[k]]
                && !(wb_v_i && wb_Rt_i == src[k]))
                hazard = 1'b1;
        end
    end

    assign dready_o = !flush_i && !hazard && (!ov_q || ordy_i);
    assign acc      = dv_i && dready_o;

    // Next state of register file, scoreboard and output bundle.
    always_comb begin
        rf_d = rf_q;
        if (wb_v_i && wr_ok_f(wb_Rt_i))
            rf_d[wb_Rt_i] = wb_res_i;

        pend_d = pend_q;
        if (wb_v_i && wr_ok_f(wb_Rt_i))
            pend_d[wb_Rt_i] = 1'b0;
        // A younger producer claims the register after the clear.
        if (acc && wrt_i && wr_ok_f(Rt_i))
            pend_d[Rt_i] = 1'b1;
        if (flush_i)
            pend_d = '0;

        if (flush_i)
            ov_d = 1'b0;
        else if (acc)
            ov_d = 1'b1;
        else if (ordy_i)
            ov_d = 1'b0;
        else
            ov_d = ov_q;

        a_d   = acc ? opnd[0] : a_q;
        b_d   = acc ? opnd[1] : b_q;
        c_d   = acc ? opnd[2] : c_q;
        rt_d  = acc ? Rt_i    : rt_q;
        wrt_d = acc ? wrt_i   : wrt_q;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NREGS; i++)
                rf_q[i] <= '0;
            pend_q <= '0;
            ov_q   <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            rt_q   <= '0;
            wrt_q  <= 1'b0;
        end else begin
            rf_q   <= rf_d;
            pend_q <= pend_d;
            ov_q   <= ov_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            rt_q   <= rt_d;
            wrt_q  <= wrt_d;
        end
    end

    assign ov_o  = ov_q;
    assign a_o   = a_q;
    assign b_o   = b_q;
    assign c_o   = c_q;
    assign Rt_o  = rt_q;
    assign wrt_o = wrt_q;

endmodule

// File: tb/tb_thor2022_operand_fetch.sv
// Bench for thor2022_operand_fetch: directed vector table, hand-written
// corner sequences, then random traffic against a reference model.
module tb_thor2022_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dv, wrt, ordy, wbv, flush;
    logic [5:0]  ra, rb, rc, rt, wbrt;
    logic [63:0] wbres;
    logic        dready, ov, wrt_out;
    logic [63:0] a, b, c;
    logic [5:0]  rt_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    thor2022_operand_fetch dut (
        .clk_i(clk), .rst_i(rst_n), .dv_i(dv), .dready_o(dready),
        .Ra_i(ra), .Rb_i(rb), .Rc_i(rc), .Rt_i(rt), .wrt_i(wrt),
        .ov_o(ov), .ordy_i(ordy), .a_o(a), .b_o(b), .c_o(c),
        .Rt_o(rt_out), .wrt_o(wrt_out), .wb_v_i(wbv),
        .wb_Rt_i(wbrt), .wb_res_i(wbres), .flush_i(flush)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic d, input logic [5:0] xa,
                         input logic [5:0] xb, input logic [5:0] xc,
                         input logic [5:0] xt, input logic w,
                         input logic o, input logic v,
                         input logic [5:0] vr, input logic [63:0] vd,
                         input logic f);
        dv = d; ra = xa; rb = xb; rc = xc; rt = xt; wrt = w;
        ordy = o; wbv = v; wbrt = vr; wbres = vd; flush = f;
    endtask

    typedef struct {
        logic        dv;
        logic [5:0]  ra, rb, rc, rt;
        logic        wrt, ordy, wbv;
        logic [5:0]  wbrt;
        logic [63:0] wbres;
        logic        flush;
        logic        e_rdy, e_ov;
        logic [63:0] e_a, e_b, e_c;
    } vec_t;

    vec_t tv [8];

    // Reference model state
    logic [63:0] m_rf [64];
    bit          m_pend [64];
    bit          m_ov, m_wrt;
    logic [63:0] m_a, m_b, m_c;
    logic [5:0]  m_rt;

    function automatic bit writable(input logic [5:0] r);
        int n = int'(r);
        return n != 0 && (n < 32 || n == 41 || n == 42 ||
                          (n >= 44 && n < 48));
    endfunction

    function automatic logic [63:0] mread(input logic [5:0] r);
        if (wbv && wbrt == r && writable(r)) return wbres;
        return m_rf[r];
    endfunction

    function automatic bit mhaz(input logic [5:0] r);
        return m_pend[r] && !(wbv && wbrt == r);
    endfunction

    initial begin
        logic [5:0] pool [16];
        bit exp_rdy, acc;
        pool = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                 6'd8, 6'd40, 6'd41, 6'd42, 6'd43, 6'd44, 6'd47, 6'd55};

        //          dv ra rb rc rt wrt ordy wbv wbrt wbres flush rdy ov a b c
        tv[0] = '{0, 6'd0, 6'd0, 6'd0, 6'd0, 0, 1, 1, 6'd5, 64'h1234, 0,
                  1, 0, 64'h0, 64'h0, 64'h0};
        tv[1] = '{1, 6'd5, 6'd0, 6'd50, 6'd7, 1, 1, 0, 6'd0, 64'h0, 0,
                  1, 1, 64'h1234, 64'h0, 64'h0};
        tv[2] = '{1, 6'd7, 6'd0, 6'd0, 6'd0, 0, 1, 0, 6'd0, 64'h0, 0,
                  0, 0, 64'h1234, 64'h0, 64'h0};
        tv[3] = '{1, 6'd7, 6'd0, 6'd0, 6'd0, 0, 1, 0, 6'd0, 64'h0, 0,
                  0, 0, 64'h1234, 64'h0, 64'h0};
        tv[4] = '{1, 6'd7, 6'd0, 6'd0, 6'd0, 0, 1, 1, 6'd7, 64'hAA, 0,
                  1, 1, 64'hAA, 64'h0, 64'h0};
        tv[5] = '{1, 6'd7, 6'd7, 6'd7, 6'd9, 1, 1, 1, 6'd9, 64'h99, 0,
                  1, 1, 64'hAA, 64'hAA, 64'hAA};
        tv[6] = '{1, 6'd9, 6'd0, 6'd0, 6'd0, 0, 1, 0, 6'd0, 64'h0, 0,
                  0, 0, 64'hAA, 64'hAA, 64'hAA};
        tv[7] = '{1, 6'd9, 6'd5, 6'd0, 6'd0, 0, 1, 1, 6'd9, 64'h55, 0,
                  1, 1, 64'h55, 64'h1234, 64'h0};

        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("reset_ov", 64'(ov), 64'h0);
        chk("reset_a", a, 64'h0);
        chk("reset_rt", 64'(rt_out), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(tv[i].dv, tv[i].ra, tv[i].rb, tv[i].rc, tv[i].rt,
                  tv[i].wrt, tv[i].ordy, tv[i].wbv, tv[i].wbrt,
                  tv[i].wbres, tv[i].flush);
            #1 chk($sformatf("vec%0d_rdy", i), 64'(dready), 64'(tv[i].e_rdy));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_ov", i), 64'(ov), 64'(tv[i].e_ov));
            chk($sformatf("vec%0d_a", i), a, tv[i].e_a);
            chk($sformatf("vec%0d_b", i), b, tv[i].e_b);
            chk($sformatf("vec%0d_c", i), c, tv[i].e_c);
        end

        // Backpressure: bundle held while execute stalls
        @(negedge clk);
        drive(1, 5, 7, 9, 12, 1, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("bp_rt", 64'(rt_out), 64'd12);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0);
            #1 chk("bp_rdy_low", 64'(dready), 64'h0);
            @(posedge clk); #1;
            chk("bp_ov", 64'(ov), 64'h1);
            chk("bp_a", a, 64'h1234);
            chk("bp_b", b, 64'hAA);
            chk("bp_c", c, 64'h55);
            chk("bp_wrt", 64'(wrt_out), 64'h1);
        end
        @(negedge clk);
        drive(1, 7, 0, 0, 0, 0, 1, 1, 6'd12, 64'h12, 0);
        #1 chk("bp_release_rdy", 64'(dready), 64'h1);
        @(posedge clk); #1;
        chk("bp_new_a", a, 64'hAA);
        chk("bp_new_ov", 64'(ov), 64'h1);

        // Flush clears scoreboard and output valid
        @(negedge clk);
        drive(1, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 3, 0, 0, 0, 0, 0, 1, 6'd3, 64'h33, 1);
        #1 chk("flush_rdy", 64'(dready), 64'h0);
        @(posedge clk); #1;
        chk("flush_ov", 64'(ov), 64'h0);
        @(negedge clk);
        drive(1, 3, 4, 0, 0, 0, 1, 0, 0, 0, 0);
        #1 chk("post_flush_rdy", 64'(dready), 64'h1);
        @(posedge clk); #1;
        chk("post_flush_a", a, 64'h33);
        chk("post_flush_b", b, 64'h0);

        // Asynchronous reset mid-transaction
        @(negedge clk);
        drive(1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        @(posedge clk); #1;
        chk("pre_rst_ov", 64'(ov), 64'h1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_ov", 64'(ov), 64'h0);
        chk("rst_a", a, 64'h0);
        chk("rst_wrt", 64'(wrt_out), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 5, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        #1 chk("rst_pend_clear", 64'(dready), 64'h1);
        @(posedge clk); #1;
        chk("rst_r5_zero", a, 64'h0);

        // Random traffic against the model, from a fresh reset
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            m_rf[i] = '0;
            m_pend[i] = 0;
        end
        m_ov = 0; m_wrt = 0; m_a = 0; m_b = 0; m_c = 0; m_rt = 0;

        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            drive($urandom_range(0, 3) != 0,
                  pool[$urandom_range(0, 15)], pool[$urandom_range(0, 15)],
                  pool[$urandom_range(0, 15)], pool[$urandom_range(0, 15)],
                  $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, pool[$urandom_range(0, 15)],
                  {$urandom, $urandom}, $urandom_range(0, 19) == 0);
            exp_rdy = !flush && !mhaz(ra) && !mhaz(rb) && !mhaz(rc)
                      && (!m_ov || ordy);
            acc = dv && exp_rdy;
            #1 chk("rnd_rdy", 64'(dready), 64'(exp_rdy));

            if (acc) begin
                m_a = mread(ra); m_b = mread(rb); m_c = mread(rc);
                m_rt = rt; m_wrt = wrt;
            end
            if (flush) m_ov = 0;
            else if (acc) m_ov = 1;
            else if (ordy) m_ov = 0;
            if (wbv) m_pend[wbrt] = 0;
            if (acc && wrt && writable(rt)) m_pend[rt] = 1;
            if (flush) for (int k = 0; k < 64; k++) m_pend[k] = 0;
            if (wbv && writable(wbrt)) m_rf[wbrt] = wbres;

            @(posedge clk); #1;
            chk("rnd_ov", 64'(ov), 64'(m_ov));
            chk("rnd_a", a, m_a);
            chk("rnd_b", b, m_b);
            chk("rnd_c", c, m_c);
            chk("rnd_rt", 64'(rt_out), 64'(m_rt));
            chk("rnd_wrt", 64'(wrt_out), 64'(m_wrt));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/thor2022_operand_fetch.md
# thor2022_operand_fetch

Register-read stage that sits directly downstream of the Thor2022 register-select decoders (Ra/Rb/Rc/Rt). It takes the decoded 6-bit register indices and produces the three 64-bit operands for execute. It holds the 48-entry architectural register file: GPRs 0-31, link registers 41-42, and stack-pointer banks 44-47. It also keeps a pending-write scoreboard, bypasses same-cycle writeback, and applies a valid/ready handshake on both sides.

## Interface
- WID, 64, operand/register width
- NREGS, 48, implemented register count; indices >= NREGS are unimplemented
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-low
- dv_i  in  1  decoded instruction valid
- dready_o  out  1  stage can accept the decoded instruction this cycle
- Ra_i, Rb_i, Rc_i  in  6 each  source register indices from decode
- Rt_i  in  6  destination register index
- wrt_i  in  1  instruction writes Rt_i
- ov_o  out  1  operand bundle valid to execute
- ordy_i  in  1  execute accepts the bundle
- a_o, b_o, c_o  out  WID each  operands for Ra/Rb/Rc
- Rt_o  out  6  registered Rt_i
- wrt_o  out  1  registered wrt_i
- wb_v_i  in  1  writeback valid
- wb_Rt_i  in  6  writeback register index
- wb_res_i  in  WID  writeback data
- flush_i  in  1  pipeline flush (branch miss / exception)

## Operation
- **Register file**
  - Reading index 0 returns 0.
  - Reading any unimplemented index (32-40, 43, >= 48) returns 0.
  - Writes to index 0 or to unimplemented indices are ignored.
  - A write occurs when wb_v_i is high; it is never blocked by a stall.
- **Scoreboard**
  - One pend bit per implemented register. Index 0 is never pending.
  - Accept = dv_i && dready_o.
  - On accept with wrt_i high and Rt_i implemented and non-zero: set pend[Rt_i].
  - On wb_v_i: clear pend[wb_Rt_i].
  - Same register set and cleared in the same cycle: set wins, because the new producer is younger.
- **Hazard**
  - A source is hazarded when its pend bit is set and it is not being cleared this cycle by wb_v_i with a matching wb_Rt_i.
  - hazard = OR of the hazard term over Ra_i, Rb_i, Rc_i.
- **Ready**
  - dready_o = !flush_i && !hazard && (!ov_o || ordy_i).
  - dready_o is combinational and does not depend on dv_i.
- **Capture on accept**
  - Operands are captured into output registers: the file value, or wb_res_i when wb_v_i is high and wb_Rt_i matches the source (bypass).
  - Rt_o and wrt_o are captured alongside.
  - ov_o is set next cycle.
- **Output valid**
  - ov_o clears when ordy_i is high and no new accept occurs.
  - While ov_o && !ordy_i, all outputs hold constant. The interlock guarantees the held operands cannot become stale.
- **Flush**
  - Next cycle ov_o = 0 and all pend bits = 0.
  - No accept occurs in the flush cycle.
  - A writeback in the flush cycle still updates the file.

## Timing
- **Reset**: all registers 0, pend = 0, ov_o = 0, a_o/b_o/c_o = 0, Rt_o = 0, wrt_o = 0. Reset takes effect immediately, mid-transaction included; no handshake completes in that cycle.
- **Latency**: 1 cycle, from accept edge to ov_o/operands valid.
- **Throughput**: one instruction per cycle when there is no hazard and ordy_i is held high.
- **Write-to-read**: a writeback in cycle N is visible to an instruction accepted in cycle N (bypass) and in any later cycle (file).
- **RAW dependence**: a consumer of a pending register stalls until the cycle its writeback is presented, and is accepted in that cycle.
- **Multiple sources**: Ra_i == Rb_i == Rc_i is legal; each operand gets the same value.

## Test plan
- **Reset**: assert rst_i low mid-stream with ov_o = 1 -> ov_o, outputs and pend bits read 0 in the same cycle; a read of r5 after release returns 0.
- **Basic write/read**: write r5 = 0x1234 via wb; next cycle accept Ra = 5, Rb = 0, Rc = 50 -> a_o = 0x1234, b_o = 0, c_o = 0, ov_o high 1 cycle later.
- **Interlock**:
  - Accept Rt = 7 with wrt_i = 1; next instruction has Ra = 7 -> dready_o = 0 until wb_v_i with wb_Rt_i = 7 and wb_res_i = 0xAA.
  - Accept occurs in that writeback cycle and a_o = 0xAA.
- **Backpressure**: hold ordy_i = 0 for 3 cycles with ov_o = 1 -> outputs unchanged and dready_o = 0; ordy_i = 1 -> bundle consumed and a new accept occurs in the same cycle.
- **Set/clear collision**: accept Rt = 9 while wb_v_i clears r9 -> pend[9] remains 1 and a following Ra = 9 stalls.
- **Flush**: flush_i with ov_o = 1 and pend[3] = 1 -> next cycle ov_o = 0 and Ra = 3 is accepted without stall; a writeback to r3 in the flush cycle lands in the file.
